// File: rtl/fp16_pkg.sv
// fp16_pkg -- shared constants and types for the FP16 to fixed-point converter.
// Holds the binary16 field widths, exponent bias/limits, the converter FSM
// state encoding, the operand class encoding and the packed field struct.
package fp16_pkg;

  localparam int FP16_W   = 16;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int SIG_W    = MANT_W + 1;   // significand including hidden bit
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_e;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_NAN  = 3'd4
  } fp16_class_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;

endpackage

// File: rtl/fp16_unpack.sv
// fp16_unpack -- combinational binary16 field decoder.
// Classifies the operand and produces the sign, the effective exponent
// (subnormals use exponent 1) and the 11-bit significand with hidden bit.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] op,
  output logic              sign,
  output fp16_class_e       op_class,
  output logic [EXP_W-1:0]  e_eff,
  output logic [SIG_W-1:0]  sig
);

  fp16_t f;
  assign f = op;

  assign sign  = f.sign;
  assign e_eff = f.exp + EXP_W'(f.exp == '0);
  assign sig   = {|f.exp, f.mant};

  // Operand classification from the exponent and mantissa fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    op_class = FP_NORM;
    if (f.exp == EXP_W'(EXP_MAX)) begin
      op_class = (f.mant == '0) ? FP_INF : FP_NAN;
    end else if (f.exp == '0) begin
      op_class = (f.mant == '0) ? FP_ZERO : FP_SUB;
    end
  end

endmodule

// File: rtl/fp16_to_fix.sv
// fp16_to_fix -- converts one IEEE-754 binary16 operand to signed fixed point
// (OUT_W bits, FRAC_W fractional bits) with a serial one-bit-per-cycle shifter.
// Handshake: valid/ready on both sides, one result in flight at a time.
// Optional build macro FP16_ROUND_NEAREST_EN: round-to-nearest-even on right
// shifts (guard/sticky tracking); otherwise right shifts truncate toward zero.
module fp16_to_fix
  import fp16_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              out_nan
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  // Shift count never needs to exceed the point where the magnitude is gone.
  localparam int CAP   = OUT_W + SIG_W;
  localparam int CNT_W = $clog2(CAP + 1);

  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] mag;
  logic             left_q;
  logic             sign_q;
  logic             inf_q;
  logic             nan_q;
  logic             ovf_sticky;   // a 1 has left the top of the magnitude
`ifdef FP16_ROUND_NEAREST_EN
  logic             guard_q;      // last bit shifted out on the right
  logic             rsticky_q;    // OR of all earlier right-shifted bits
`endif

  // Operand decode.
  logic              u_sign;
  fp16_class_e       u_class;
  logic [EXP_W-1:0]  u_e_eff;
  logic [SIG_W-1:0]  u_sig;

  fp16_unpack u_unpack (
    .op       (in_data),
    .sign     (u_sign),
    .op_class (u_class),
    .e_eff    (u_e_eff),
    .sig      (u_sig)
  );

  // sh = e_eff - bias - mantissa width + FRAC_W, held in 8-bit two's complement.
  logic [7:0]       sh_raw;
  logic [7:0]       sh_abs;
  logic             sh_left;
  logic             special;
  logic [CNT_W-1:0] cnt_load;

  assign sh_raw   = 8'(u_e_eff) + 8'(FRAC_W) - 8'(EXP_BIAS + MANT_W);
  assign sh_left  = ~sh_raw[7];
  assign sh_abs   = sh_raw[7] ? (~sh_raw + 8'd1) : sh_raw;
  assign special  = (u_class == FP_ZERO) || (u_class == FP_INF) || (u_class == FP_NAN);
  assign cnt_load = special        ? '0 :
                    (sh_abs > 8'(CAP)) ? CNT_W'(CAP) : CNT_W'(sh_abs);

  // Final magnitude, optionally rounded to nearest-even, one bit wider so a
  // round-up carry is seen by the saturation check.
  logic [OUT_W:0] mag_fin;
`ifdef FP16_ROUND_NEAREST_EN
  logic round_up;
  assign round_up = guard_q & (rsticky_q | mag[0]);
  assign mag_fin  = {1'b0, mag} + (OUT_W+1)'(round_up);
`else
  assign mag_fin  = {1'b0, mag};
`endif

  logic [OUT_W-1:0] res_data;
  logic             res_ovf;
  logic             res_nan;

  // Apply sign, saturation and special-operand results to the final magnitude.
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    res_nan  = 1'b0;
    if (nan_q) begin
      res_nan = 1'b1;
    end else if (inf_q) begin
      res_data = sign_q ? NEG_MIN : POS_MAX;
      res_ovf  = 1'b1;
    end else if (sign_q) begin
      if (ovf_sticky || (mag_fin > {1'b0, NEG_MIN})) begin
        res_data = NEG_MIN;
        res_ovf  = 1'b1;
      end else begin
        res_data = '0 - mag_fin[OUT_W-1:0];
      end
    end else begin
      if (ovf_sticky || (mag_fin > {1'b0, POS_MAX})) begin
        res_data = POS_MAX;
        res_ovf  = 1'b1;
      end else begin
        res_data = mag_fin[OUT_W-1:0];
      end
    end
  end

  // FSM, serial shifter and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mag        <= '0;
      left_q     <= 1'b0;
      sign_q     <= 1'b0;
      inf_q      <= 1'b0;
      nan_q      <= 1'b0;
      ovf_sticky <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      out_nan    <= 1'b0;
`ifdef FP16_ROUND_NEAREST_EN
      guard_q    <= 1'b0;
      rsticky_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= SHIFT;
            mag        <= OUT_W'(u_sig);
            cnt        <= cnt_load;
            left_q     <= sh_left;
            sign_q     <= u_sign;
            inf_q      <= (u_class == FP_INF);
            nan_q      <= (u_class == FP_NAN);
            ovf_sticky <= 1'b0;
`ifdef FP16_ROUND_NEAREST_EN
            guard_q    <= 1'b0;
            rsticky_q  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (left_q) begin
              ovf_sticky <= ovf_sticky | mag[OUT_W-1];
              mag        <= mag << 1;
            end else begin
              mag        <= mag >> 1;
`ifdef FP16_ROUND_NEAREST_EN
              guard_q    <= mag[0];
              rsticky_q  <= rsticky_q | guard_q;
`endif
            end
          end else begin
            state    <= DONE;
            out_data <= res_data;
            out_ovf  <= res_ovf;
            out_nan  <= res_nan;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp16_to_fix.sv
// tb_fp16_to_fix -- table-driven bench for fp16_to_fix (OUT_W=16, FRAC_W=4)
// with a scoreboard queue, plus back-pressure and reset-abort sequences.
// Expected values follow FP16_ROUND_NEAREST_EN when the bench is built with it.
module tb_fp16_to_fix;

  localparam int OUT_W  = 16;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              out_ovf;
  logic              out_nan;

  fp16_to_fix #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] din;
    logic [15:0] data;
    logic        ovf;
    logic        nan;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present an operand and wait (bounded) for it to be accepted; acc is the
  // cycle index whose closing edge performs the transfer.
  task automatic send(input logic [15:0] din, output int acc);
    @(negedge clk);
    in_data  = din;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check($sformatf("%h accept", din), 32'(in_ready), 32'd1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc, output int lat);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check("out_valid seen", 32'(out_valid), 32'd1);
    lat = cyc - acc;
  endtask

  task automatic compare_out(input int lat);
    vec_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: result with no expected entry, data 0x%0h", out_data);
    end else begin
      e = sb.pop_front();
      check($sformatf("%h data", e.din), 32'(out_data), 32'(e.data));
      check($sformatf("%h ovf", e.din),  32'(out_ovf),  32'(e.ovf));
      check($sformatf("%h nan", e.din),  32'(out_nan),  32'(e.nan));
      check($sformatf("%h latency", e.din), 32'(lat), 32'(e.lat));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int acc, lat;
    sb.push_back(v);
    send(v.din, acc);
    wait_out(acc, lat);
    compare_out(lat);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e_2a00, e_3c60, e_bc60;
    int acc, lat, seen;
    vec_t v;

`ifdef FP16_ROUND_NEAREST_EN
    e_2a00 = 16'h0001;  // 0.75 LSB rounds up
    e_3c60 = 16'h0012;  // 17.5 ties to even 18
    e_bc60 = 16'hFFEE;  // -17.5 ties to even -18
`else
    e_2a00 = 16'h0000;
    e_3c60 = 16'h0011;
    e_bc60 = 16'hFFEF;
`endif

    //                din       data      ovf   nan   latency
    vecs.push_back('{16'h3C00, 16'h0010, 1'b0, 1'b0, 8});   // 1.0
    vecs.push_back('{16'hC100, 16'hFFD8, 1'b0, 1'b0, 7});   // -2.5
    vecs.push_back('{16'hE800, 16'h8000, 1'b0, 1'b0, 7});   // -2048 exact min
    vecs.push_back('{16'h6C00, 16'h7FFF, 1'b1, 1'b0, 8});   // 4096 saturates
    vecs.push_back('{16'h6800, 16'h7FFF, 1'b1, 1'b0, 7});   // 2048 just over max
    vecs.push_back('{16'h67FF, 16'h7FF0, 1'b0, 1'b0, 6});   // 2047 fits
    vecs.push_back('{16'hE7FF, 16'h8010, 1'b0, 1'b0, 6});   // -2047
    vecs.push_back('{16'hFC00, 16'h8000, 1'b1, 1'b0, 2});   // -inf
    vecs.push_back('{16'h7C00, 16'h7FFF, 1'b1, 1'b0, 2});   // +inf
    vecs.push_back('{16'h7E00, 16'h0000, 1'b0, 1'b1, 2});   // qNaN
    vecs.push_back('{16'hFC01, 16'h0000, 1'b0, 1'b1, 2});   // negative NaN
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 2});   // +0
    vecs.push_back('{16'h8000, 16'h0000, 1'b0, 1'b0, 2});   // -0
    vecs.push_back('{16'h2A00, e_2a00,   1'b0, 1'b0, 13});  // 0.046875
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 22});  // min subnormal
    vecs.push_back('{16'h0400, 16'h0000, 1'b0, 1'b0, 22});  // min normal
    vecs.push_back('{16'h4900, 16'h00A0, 1'b0, 1'b0, 5});   // 10.0
    vecs.push_back('{16'h5BFF, 16'h0FFE, 1'b0, 1'b0, 3});   // 255.875, left by 1
    vecs.push_back('{16'h3555, 16'h0005, 1'b0, 1'b0, 10});  // ~0.333
    vecs.push_back('{16'h3C20, 16'h0010, 1'b0, 1'b0, 8});   // 16.5 LSB tie to even
    vecs.push_back('{16'h3C60, e_3c60,   1'b0, 1'b0, 8});   // 17.5 LSB
    vecs.push_back('{16'hBC60, e_bc60,   1'b0, 1'b0, 8});   // -17.5 LSB

    // Reset.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  32'(out_data),  32'd0);
    check("reset out_ovf",   32'(out_ovf),   32'd0);
    check("reset out_nan",   32'(out_nan),   32'd0);

    // Table.
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Back-pressure: result held for 5 cycles, new operand refused meanwhile.
    out_ready = 1'b0;
    v = '{16'h3C00, 16'h0010, 1'b0, 1'b0, 8};
    sb.push_back(v);
    send(v.din, acc);
    wait_out(acc, lat);
    compare_out(lat);
    for (int i = 0; i < 5; i++) begin
      in_data  = 16'h4900;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data",  32'(out_data),  32'h0010);
      check("bp in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready",  32'(in_ready),  32'd1);

    // Reset mid-SHIFT: result discarded.
    send(16'h0001, acc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort shift in_ready",  32'(in_ready),  32'd1);
    check("abort shift out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort shift no result", 32'(seen), 32'd0);

    // Reset in DONE: held result dropped, registers cleared.
    out_ready = 1'b0;
    send(16'h4900, acc);
    wait_out(acc, lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("abort done out_valid", 32'(out_valid), 32'd0);
    check("abort done out_data",  32'(out_data),  32'd0);
    check("abort done in_ready",  32'(in_ready),  32'd1);

    // Recovery after abort.
    run_vec('{16'hC100, 16'hFFD8, 1'b0, 1'b0, 7});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
